varredura_vga_quadro: RTL and testbench

// - Scan-out stage downstream of the frame-buffer RAM (640x480, 24-bit RGB, 1-clk registered read).
// - Generates VGA timing, issues one RAM read address per pixel, and drives RGB, sync and data-enable pins.
// - Pulses a vertical-blank marker so game logic can update the frame buffer outside active video.

---
 rtl/varredura_vga_quadro.sv | 199 +++++++++++++++++++
 tb/tb_varredura_vga_quadro.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/varredura_vga_quadro.sv
`default_nettype none
// ============================================================================
// Module    : varredura_vga_quadro
// Purpose   : VGA scan-out for a 640x480 24-bit frame buffer. Generates the
//             H/V timing, issues one RAM read address per active pixel, and
//             drives registered RGB/HS/VS/DE pins plus a vertical-blank marker.
//             All pins share a fixed 3-clk latency from the pixel counters.
// Options   : PADRAO_TESTE_EN adds input padrao_teste and an 8-bar colour
//             test pattern that replaces RAM data in active video.
// Revision  : 1.0 - initial release
// ============================================================================
module varredura_vga_quadro #(
  parameter int H_ATIVO  = 640,
  parameter int H_FRENTE = 16,
  parameter int H_SYNC   = 96,
  parameter int H_TRAS   = 48,
  parameter int V_ATIVO  = 480,
  parameter int V_FRENTE = 10,
  parameter int V_SYNC   = 2,
  parameter int V_TRAS   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
`ifdef PADRAO_TESTE_EN
  input  logic        padrao_teste,
`endif
  output logic [18:0] endereco,
  input  logic [23:0] dado_ram,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic        inicio_vblank
);

  localparam int c_h_total = H_ATIVO + H_FRENTE + H_SYNC + H_TRAS;
  localparam int c_v_total = V_ATIVO + V_FRENTE + V_SYNC + V_TRAS;
  localparam int c_hc_w    = $clog2(c_h_total);
  localparam int c_vc_w    = $clog2(c_v_total);

  localparam logic [c_hc_w-1:0] c_h_max   = c_hc_w'(c_h_total - 1);
  localparam logic [c_hc_w-1:0] c_h_ativo = c_hc_w'(H_ATIVO);
  localparam logic [c_hc_w-1:0] c_hs_ini  = c_hc_w'(H_ATIVO + H_FRENTE);
  localparam logic [c_hc_w-1:0] c_hs_fim  = c_hc_w'(H_ATIVO + H_FRENTE + H_SYNC);
  localparam logic [c_vc_w-1:0] c_v_max   = c_vc_w'(c_v_total - 1);
  localparam logic [c_vc_w-1:0] c_v_ativo = c_vc_w'(V_ATIVO);
  localparam logic [c_vc_w-1:0] c_vs_ini  = c_vc_w'(V_ATIVO + V_FRENTE);
  localparam logic [c_vc_w-1:0] c_vs_fim  = c_vc_w'(V_ATIVO + V_FRENTE + V_SYNC);

  // Stage t: pixel counters and read address
  logic [c_hc_w-1:0] hc_q, hc_d;
  logic [c_vc_w-1:0] vc_q, vc_d;
  logic [18:0]       end_q, end_d;

  // Stages t+1 / t+2: control bits travelling alongside the RAM read
  logic s1_de_q, s1_de_d, s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d, s1_vb_q, s1_vb_d;
  logic s2_de_q, s2_de_d, s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d, s2_vb_q, s2_vb_d;

  // Output stage: pin registers (HS/VS hold the actual pin level)
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, vb_q, vb_d;
  logic [23:0] rgb_q, rgb_d;

  logic w_ativo, w_hs, w_vs, w_vb, w_fim_linha, w_fim_quadro;

  assign w_fim_linha  = (hc_q == c_h_max);
  assign w_fim_quadro = w_fim_linha && (vc_q == c_v_max);
  assign w_ativo      = (hc_q < c_h_ativo) && (vc_q < c_v_ativo);
  assign w_hs         = (hc_q >= c_hs_ini) && (hc_q < c_hs_fim);
  assign w_vs         = (vc_q >= c_vs_ini) && (vc_q < c_vs_fim);
  assign w_vb         = (hc_q == '0) && (vc_q == c_v_ativo);

`ifdef PADRAO_TESTE_EN
  localparam int c_barra = H_ATIVO / 8;

  logic       s1_pad_q, s1_pad_d, s2_pad_q, s2_pad_d;
  logic [2:0] s1_barra_q, s1_barra_d, s2_barra_q, s2_barra_d;
  logic [2:0] w_barra;

  // Bar index of the current pixel: number of bar boundaries already crossed
  always_comb begin
    w_barra = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (hc_q >= c_hc_w'(k * c_barra)) begin
        w_barra = w_barra + 3'd1;
      end
    end
  end
`endif

  // Next-state: counters, incrementing address and the 3-stage pin pipeline
  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (w_fim_linha) begin
      hc_d = '0;
      vc_d = w_fim_quadro ? '0 : vc_q + 1'b1;
    end

    // Address restarts at the first pixel of each frame, then counts active pixels
    end_d = end_q;
    if (w_fim_quadro) begin
      end_d = '0;
    end else if (w_ativo) begin
      end_d = ((hc_q == '0) && (vc_q == '0)) ? 19'd0 : end_q + 19'd1;
    end

    s1_de_d = w_ativo;
    s1_hs_d = w_hs;
    s1_vs_d = w_vs;
    s1_vb_d = w_vb;
    s2_de_d = s1_de_q;
    s2_hs_d = s1_hs_q;
    s2_vs_d = s1_vs_q;
    s2_vb_d = s1_vb_q;

    de_d  = s2_de_q;
    hs_d  = s2_hs_q ? SYNC_POL : ~SYNC_POL;
    vs_d  = s2_vs_q ? SYNC_POL : ~SYNC_POL;
    vb_d  = s2_vb_q;
    rgb_d = s2_de_q ? dado_ram : 24'h000000;

`ifdef PADRAO_TESTE_EN
    s1_pad_d   = padrao_teste;
    s1_barra_d = w_barra;
    s2_pad_d   = s1_pad_q;
    s2_barra_d = s1_barra_q;
    // Bar order white,yellow,cyan,green,magenta,red,blue,black maps to inverted index bits
    if (s2_de_q && s2_pad_q) begin
      rgb_d = {{8{~s2_barra_q[1]}}, {8{~s2_barra_q[2]}}, {8{~s2_barra_q[0]}}};
    end
`endif
  end

  // State registers; reset flushes the pipeline so pins come out inactive
  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q    <= '0;
      vc_q    <= '0;
      end_q   <= '0;
      s1_de_q <= 1'b0;
      s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0;
      s1_vb_q <= 1'b0;
      s2_de_q <= 1'b0;
      s2_hs_q <= 1'b0;
      s2_vs_q <= 1'b0;
      s2_vb_q <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      vb_q    <= 1'b0;
      rgb_q   <= '0;
`ifdef PADRAO_TESTE_EN
      s1_pad_q   <= 1'b0;
      s1_barra_q <= '0;
      s2_pad_q   <= 1'b0;
      s2_barra_q <= '0;
`endif
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      end_q   <= end_d;
      s1_de_q <= s1_de_d;
      s1_hs_q <= s1_hs_d;
      s1_vs_q <= s1_vs_d;
      s1_vb_q <= s1_vb_d;
      s2_de_q <= s2_de_d;
      s2_hs_q <= s2_hs_d;
      s2_vs_q <= s2_vs_d;
      s2_vb_q <= s2_vb_d;
      de_q    <= de_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      vb_q    <= vb_d;
      rgb_q   <= rgb_d;
`ifdef PADRAO_TESTE_EN
      s1_pad_q   <= s1_pad_d;
      s1_barra_q <= s1_barra_d;
      s2_pad_q   <= s2_pad_d;
      s2_barra_q <= s2_barra_d;
`endif
    end
  end

  assign endereco      = end_q;
  assign vga_r         = rgb_q[23:16];
  assign vga_g         = rgb_q[15:8];
  assign vga_b         = rgb_q[7:0];
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_de        = de_q;
  assign inicio_vblank = vb_q;

endmodule

`default_nettype wire

// File: tb/tb_varredura_vga_quadro.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module    : tb_varredura_vga_quadro
// Purpose   : Self-checking bench for varredura_vga_quadro using reduced
//             timing. Expected pins come from the screen position reached
//             since the last reset; expected colours go through a queue.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_varredura_vga_quadro;

  localparam int HA = 64, HF = 4, HS = 8, HB = 6;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int END_MAX = HA * VA - 1;
  localparam bit SP = 1'b0;
`ifdef PADRAO_TESTE_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif
  localparam logic [23:0] BARRAS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        padrao_teste = 1'b0;
  logic [18:0] endereco;
  logic [23:0] dado_ram = '0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_de, inicio_vblank;
  logic [23:0] ram_mask = '0;

  int          n_chk = 0;
  int          n_fail = 0;
  int          since = 0;
  bit          primed = 1'b0;
  logic [23:0] exp_q [$];

  varredura_vga_quadro #(
    .H_ATIVO(HA), .H_FRENTE(HF), .H_SYNC(HS), .H_TRAS(HB),
    .V_ATIVO(VA), .V_FRENTE(VF), .V_SYNC(VS), .V_TRAS(VB),
    .SYNC_POL(SP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef PADRAO_TESTE_EN
    .padrao_teste  (padrao_teste),
`endif
    .endereco      (endereco),
    .dado_ram      (dado_ram),
    .vga_r         (vga_r),
    .vga_g         (vga_g),
    .vga_b         (vga_b),
    .vga_hs        (vga_hs),
    .vga_vs        (vga_vs),
    .vga_de        (vga_de),
    .inicio_vblank (inicio_vblank)
  );

  always #5 clk = ~clk;

  // Frame-buffer RAM model: one-clock registered read
  function automatic logic [23:0] ram_fn(input logic [18:0] a, input logic [23:0] m);
    return {5'b0, a} ^ m;
  endfunction

  always @(posedge clk) dado_ram <= ram_fn(endereco, ram_mask);

  // Expected {de,hs,vs,vblank} n clocks after the last reset edge
  function automatic logic [3:0] pinos_esperados(input int n);
    int p, x, y;
    logic de, ha, va, vb;
    if (n < 3) return {1'b0, ~SP, ~SP, 1'b0};
    p  = (n - 3) % FRAME;
    x  = p % HT;
    y  = p / HT;
    de = (x < HA) && (y < VA);
    ha = (x >= HA + HF) && (x < HA + HF + HS);
    va = (y >= VA + VF) && (y < VA + VF + VS);
    vb = (x == 0) && (y == VA);
    return {de, ha ? SP : ~SP, va ? SP : ~SP, vb};
  endfunction

  // Producer: track screen position and queue the colour each active pixel must show
  always @(posedge clk) begin
    int p, px, py;
    logic [23:0] e;
    if (reset) begin
      since  = 0;
      primed = 1'b1;
      exp_q.delete();
    end else begin
      since++;
    end
    #2;
    p  = since % FRAME;
    px = p % HT;
    py = p / HT;
    if (px < HA && py < VA) begin
      if (PAT_EN && padrao_teste) e = BARRAS[px / (HA / 8)];
      else                        e = ram_fn(19'(py * HA + px), ram_mask);
      exp_q.push_back(e);
    end
  end

  // Monitor: check pins every cycle and pop a colour whenever DE is presented
  always @(negedge clk) begin
    logic [3:0]  w;
    logic [23:0] e;
    if (primed) begin
      w = pinos_esperados(since);
      n_chk++;
      if ({vga_de, vga_hs, vga_vs, inicio_vblank} !== w) begin
        n_fail++;
        $display("FAIL pins t=%0t n=%0d got de/hs/vs/vb=%b want %b",
                 $time, since, {vga_de, vga_hs, vga_vs, inicio_vblank}, w);
      end
      n_chk++;
      if (vga_de === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rgb_underflow t=%0t got %h want <none queued>", $time, {vga_r, vga_g, vga_b});
        end else begin
          e = exp_q.pop_front();
          if ({vga_r, vga_g, vga_b} !== e) begin
            n_fail++;
            $display("FAIL rgb t=%0t n=%0d got %h want %h", $time, since, {vga_r, vga_g, vga_b}, e);
          end
        end
      end else if ({vga_r, vga_g, vga_b} !== 24'h000000) begin
        n_fail++;
        $display("FAIL rgb_blank t=%0t n=%0d got %h want 000000", $time, since, {vga_r, vga_g, vga_b});
      end
      n_chk++;
      if (!(endereco <= 19'(END_MAX))) begin
        n_fail++;
        $display("FAIL addr_range t=%0t got %0d want <= %0d", $time, endereco, END_MAX);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus: power-on reset, mid-frame reset, then randomized frames
  initial begin
    int alvo;
    int lim;
    reset = 1'b1;
    repeat (5) step();
    reset = 1'b0;
    repeat (2 * FRAME + 200) step();

    // Reset for one clock at hc=30, vc=20
    alvo = 20 * HT + 30;
    lim  = 0;
    while ((since % FRAME) != alvo && lim < 2 * FRAME) begin
      step();
      lim++;
    end
    n_chk++;
    if ((since % FRAME) != alvo) begin
      n_fail++;
      $display("FAIL midframe_wait got pos %0d want %0d", since % FRAME, alvo);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (FRAME + 100) step();

    // Randomized RAM contents, pattern select and reset points
    for (int it = 0; it < 4; it++) begin
      reset = 1'b1;
      ram_mask = 24'($urandom);
      repeat (2) step();
      reset = 1'b0;
      lim = int'($urandom_range(FRAME / 2, FRAME + 500));
      for (int c = 0; c < lim; c++) begin
        padrao_teste = 1'($urandom_range(0, 1));
        step();
      end
    end
    padrao_teste = 1'b0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog t=%0t got timeout want finish", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
